instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/instr_fetch_imm_gen.sv | 26 ++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, NOP encoding, FSM states.
package instr_fetch_pkg;

    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_REG   = 7'b0110011;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_imm_gen.sv
// Immediate generator: U-type for LUI, sign-extended I-type for everything else.
module instr_fetch_imm_gen
    import instr_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [19:0]     ir_hi,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] u_imm;
    logic signed [31:0] i_imm;

    always_comb begin
        u_imm = $signed({ir_hi, 12'b0});
        i_imm = 32'($signed(ir_hi[19:8]));
        case (opcode)
            OP_LUI:  imm = XLEN'(u_imm);
            OP_IMM:  imm = XLEN'(i_imm);
            OP_REG:  imm = XLEN'(i_imm);
            default: imm = XLEN'(i_imm);
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IR fetch FSM (IDLE/REQ/DONE) and field decode.
// Optional PC alignment check enabled by defining PC_ALIGN_CHECK_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PC_Write,
    input  logic            IR_Write,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_load_val,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            fetch_busy,
    output logic            ir_valid,
`ifdef PC_ALIGN_CHECK_EN
    output logic            misalign_err,
`endif
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     ir_q, ir_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
`ifdef PC_ALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
`endif

    // Redirect wins over sequential increment; increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_load_val;
        end else if (PC_Write) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Fetch FSM next state; registered outputs are derived from the next state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (IR_Write) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (pc_q[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d  = pc_q;
                        state_d = ST_REQ;
                    end
`else
                    addr_d  = pc_q;
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d == ST_REQ);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            ir_q       <= NOP_INSN;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign pc         = pc_q;
    assign imem_req   = busy_q;
    assign fetch_busy = busy_q;
    assign imem_addr  = addr_q;
    assign ir_valid   = valid_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`endif

    // Field decode straight from IR.
    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign rd     = ir_q[11:7];

    instr_fetch_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .opcode (ir_q[6:0]),
        .ir_hi  (ir_q[31:12]),
        .imm    (imm)
    );

endmodule
